// File: rtl/dmem_pipe.sv
// dmem_pipe: data memory for the RV32 MEM stage.
// Byte/half/word loads and stores through a valid/ready request port, with a
// fixed read latency, error reporting for misaligned, out-of-range or illegal
// requests, and a sweep that clears every word after reset.
module dmem_pipe #(
   parameter int          MEM_DEPTH = 256,
   parameter int          RD_LAT    = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_load_sel,
   input  logic [1:0]  req_store_sel,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        init_done
);

   localparam int          IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [31:0] DEPTH_32 = 32'(MEM_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state;
   logic [IDX_W-1:0] sweep_idx;
   logic [31:0]      mem [MEM_DEPTH];

   logic [31:0]      off;
   logic [1:0]       lane;
   logic [IDX_W-1:0] idx;
   logic             in_range;
   logic             accept;
   logic [31:0]      rd_word;

   logic             is_half;
   logic             is_word;
   logic             sel_err;
   logic             misaligned;
   logic             req_err;

   logic [7:0]       byte_val;
   logic [15:0]      half_val;
   logic [31:0]      load_data;
   logic [31:0]      resp_data_next;
   logic [31:0]      wr_word;
   logic             do_store;

   logic             pipe_valid [RD_LAT];
   logic [31:0]      pipe_rdata [RD_LAT];
   logic             pipe_err   [RD_LAT];

   // Addresses below BASE_ADDR wrap to huge offsets and so fall out of range.
   assign off      = req_addr - BASE_ADDR;
   assign lane     = off[1:0];
   assign idx      = off[IDX_W+1:2];
   assign in_range = ({2'b00, off[31:2]} < DEPTH_32);

   assign req_ready = (state == ST_RUN);
   assign init_done = (state == ST_RUN);
   assign accept    = req_valid & req_ready;
   assign rd_word   = mem[idx];
   assign do_store  = accept & req_we & ~req_err;

   // Classify the access size and flag misalignment, range and illegal store_sel.
   always_comb begin
      is_half = 1'b0;
      is_word = 1'b0;
      sel_err = 1'b0;
      if (req_we) begin
         case (req_store_sel)
            2'b01:   is_half = 1'b1;
            2'b10:   is_word = 1'b1;
            2'b11:   sel_err = 1'b1;
            default: ;
         endcase
      end else begin
         case (req_load_sel)
            3'b000, 3'b100: ;
            3'b001, 3'b101: is_half = 1'b1;
            default:        is_word = 1'b1;
         endcase
      end
      misaligned = (is_half & lane[0]) | (is_word & (lane != 2'b00));
      req_err    = misaligned | ~in_range | sel_err;
   end

   // Pick the addressed lane out of the read word and extend it to 32 bits.
   always_comb begin
      case (lane)
         2'd0:    byte_val = rd_word[7:0];
         2'd1:    byte_val = rd_word[15:8];
         2'd2:    byte_val = rd_word[23:16];
         default: byte_val = rd_word[31:24];
      endcase
      half_val = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (req_load_sel)
         3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
         3'b001:  load_data = {{16{half_val[15]}}, half_val};
         3'b100:  load_data = {24'h0, byte_val};
         3'b101:  load_data = {16'h0, half_val};
         default: load_data = rd_word;
      endcase
      resp_data_next = (req_we | req_err) ? 32'h0 : load_data;
   end

   // Merge store data into the current word so one full-word write commits it.
   always_comb begin
      wr_word = rd_word;
      case (req_store_sel)
         2'b00: begin
            case (lane)
               2'd0:    wr_word[7:0]   = req_wdata[7:0];
               2'd1:    wr_word[15:8]  = req_wdata[7:0];
               2'd2:    wr_word[23:16] = req_wdata[7:0];
               default: wr_word[31:24] = req_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (lane[1]) begin
               wr_word[31:16] = req_wdata[15:0];
            end else begin
               wr_word[15:0] = req_wdata[15:0];
            end
         end
         2'b10:   wr_word = req_wdata;
         default: ;
      endcase
   end

   // Control FSM: clear sweep after reset, then serve requests indefinitely.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_INIT;
         sweep_idx <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               sweep_idx <= sweep_idx + IDX_W'(1);
               if (sweep_idx == LAST_IDX) begin
                  state <= ST_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   // Memory array: sweep writes zeros during INIT, legal stores commit in RUN.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == ST_INIT) begin
            mem[sweep_idx] <= 32'h0;
         end else if (do_store) begin
            mem[idx] <= wr_word;
         end
      end
   end

   // Latency pipeline: stage 0 captures the response at acceptance, later stages delay it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_rdata[i] <= 32'h0;
            pipe_err[i]   <= 1'b0;
         end
      end else begin
         pipe_valid[0] <= accept;
         pipe_rdata[0] <= accept ? resp_data_next : 32'h0;
         pipe_err[0]   <= accept & req_err;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_rdata[i] <= pipe_rdata[i-1];
            pipe_err[i]   <= pipe_err[i-1];
         end
      end
   end

   assign resp_valid = pipe_valid[RD_LAT-1];
   assign resp_rdata = pipe_rdata[RD_LAT-1];
   assign resp_err   = pipe_err[RD_LAT-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: drives the same request stream into a latency-1 and a
// latency-3 instance; expected responses go into per-instance queues and
// monitors compare data, error flag and arrival cycle.
module tb_dmem_pipe;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LX  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [1:0] SB  = 2'b00;
   localparam logic [1:0] SH  = 2'b01;
   localparam logic [1:0] SW  = 2'b10;
   localparam logic [1:0] SX  = 2'b11;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          exp_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [2:0]  req_load_sel = 3'b010;
   logic [1:0]  req_store_sel = 2'b10;

   logic        req_ready1, resp_valid1, resp_err1, init_done1;
   logic [31:0] resp_rdata1;
   logic        req_ready3, resp_valid3, resp_err3, init_done3;
   logic [31:0] resp_rdata3;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q1[$];
   exp_t q3[$];
   exp_t keep[$];

   dmem_pipe #(.MEM_DEPTH(256), .RD_LAT(1), .BASE_ADDR(32'h0)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_load_sel(req_load_sel), .req_store_sel(req_store_sel),
      .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
      .init_done(init_done1)
   );

   dmem_pipe #(.MEM_DEPTH(256), .RD_LAT(3), .BASE_ADDR(32'h0)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_load_sel(req_load_sel), .req_store_sel(req_store_sel),
      .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
      .init_done(init_done3)
   );

   always #5 clk = ~clk;

   // Edge counter used to timestamp acceptance and response arrival.
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // Compare one observed response against the expected queue entry.
   task automatic checkOutput(input string name, input exp_t e,
                              input logic [31:0] rd, input logic er);
      checks++;
      if (rd !== e.rdata || er !== e.err || cyc != e.exp_cyc) begin
         errors++;
         $display("[TB] FAIL %s resp: got rdata=%08h err=%b cyc=%0d, want rdata=%08h err=%b cyc=%0d",
                  name, rd, er, cyc, e.rdata, e.err, e.exp_cyc);
      end
   endtask

   // Monitor for the latency-1 instance.
   always @(negedge clk) begin
      if (q1.size() > 0 && q1[0].exp_cyc < cyc) begin
         checks++;
         errors++;
         $display("[TB] FAIL lat1 missing response: got none by cyc=%0d, want at cyc=%0d", cyc, q1[0].exp_cyc);
         void'(q1.pop_front());
      end
      if (resp_valid1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL lat1 unexpected response: got rdata=%08h err=%b cyc=%0d, want none",
                     resp_rdata1, resp_err1, cyc);
         end else begin
            checkOutput("lat1", q1.pop_front(), resp_rdata1, resp_err1);
         end
      end
   end

   // Monitor for the latency-3 instance.
   always @(negedge clk) begin
      if (q3.size() > 0 && q3[0].exp_cyc < cyc) begin
         checks++;
         errors++;
         $display("[TB] FAIL lat3 missing response: got none by cyc=%0d, want at cyc=%0d", cyc, q3[0].exp_cyc);
         void'(q3.pop_front());
      end
      if (resp_valid3 === 1'b1) begin
         if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL lat3 unexpected response: got rdata=%08h err=%b cyc=%0d, want none",
                     resp_rdata3, resp_err3, cyc);
         end else begin
            checkOutput("lat3", q3.pop_front(), resp_rdata3, resp_err3);
         end
      end
   end

   // Drive one request for a cycle and queue its expected response for both instances.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] lsel, input logic [1:0] ssel,
                                input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      @(negedge clk);
      req_valid     = 1'b1;
      req_we        = we;
      req_addr      = addr;
      req_wdata     = wdata;
      req_load_sel  = lsel;
      req_store_sel = ssel;
      e.rdata   = exp_rdata;
      e.err     = exp_err;
      e.exp_cyc = cyc + 1;
      q1.push_back(e);
      e.exp_cyc = cyc + 3;
      q3.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   // Release reset and verify the sweep finishes exactly 256 cycles later.
   task automatic releaseAndWaitInit(input logic poke_during_init);
      int c0;
      int n;
      @(negedge clk);
      rst_n = 1'b1;
      c0 = cyc;
      if (poke_during_init) begin
         req_valid     = 1'b1;
         req_we        = 1'b1;
         req_addr      = 32'h40;
         req_wdata     = 32'h1234_5678;
         req_store_sel = SW;
      end
      n = 0;
      while (!(init_done1 === 1'b1 || init_done3 === 1'b1) && n < 400) begin
         @(negedge clk);
         n++;
         if (n == 10) req_valid = 1'b0;
      end
      checks++;
      if (init_done1 !== 1'b1 || init_done3 !== 1'b1 || req_ready1 !== 1'b1 ||
          req_ready3 !== 1'b1 || (cyc - c0) != 256) begin
         errors++;
         $display("[TB] FAIL init_sweep: got done=%b/%b ready=%b/%b after %0d cycles, want all 1 after 256",
                  init_done1, init_done3, req_ready1, req_ready3, cyc - c0);
      end
   endtask

   task automatic checkResetState();
      checks++;
      if (req_ready1 !== 1'b0 || resp_valid1 !== 1'b0 || resp_rdata1 !== 32'h0 ||
          resp_err1 !== 1'b0 || init_done1 !== 1'b0 || req_ready3 !== 1'b0 ||
          resp_valid3 !== 1'b0 || resp_rdata3 !== 32'h0 || resp_err3 !== 1'b0 ||
          init_done3 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: got ready=%b/%b valid=%b/%b rdata=%08h/%08h err=%b/%b done=%b/%b, want all 0",
                  req_ready1, req_ready3, resp_valid1, resp_valid3, resp_rdata1, resp_rdata3,
                  resp_err1, resp_err3, init_done1, init_done3);
      end
   endtask

   initial begin
      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkResetState();
      releaseAndWaitInit(1'b1);

      // Cleared memory, including a store attempted during the sweep.
      applyStimulus(1'b0, 32'h40, 32'h0, LW, SW, 32'h0000_0000, 1'b0);

      // Sub-word loads of one stored word, back to back.
      applyStimulus(1'b1, 32'h10, 32'h8000_7F81, LW, SW, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h10, 32'h0, LB,  SW, 32'hFFFF_FF81, 1'b0);
      applyStimulus(1'b0, 32'h10, 32'h0, LBU, SW, 32'h0000_0081, 1'b0);
      applyStimulus(1'b0, 32'h12, 32'h0, LH,  SW, 32'hFFFF_8000, 1'b0);
      applyStimulus(1'b0, 32'h12, 32'h0, LHU, SW, 32'h0000_8000, 1'b0);
      applyStimulus(1'b0, 32'h13, 32'h0, LB,  SW, 32'hFFFF_FF80, 1'b0);
      applyStimulus(1'b0, 32'h11, 32'h0, LBU, SW, 32'h0000_007F, 1'b0);

      // Byte and half stores merge into an existing word.
      applyStimulus(1'b1, 32'h20, 32'h1122_3344, LW, SW, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h21, 32'hFFFF_FFAA, LW, SB, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h20, 32'h0, LW, SW, 32'h1122_AA44, 1'b0);
      applyStimulus(1'b1, 32'h22, 32'h0000_BEEF, LW, SH, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h20, 32'h0, LW, SW, 32'hBEEF_AA44, 1'b0);
      applyStimulus(1'b0, 32'h20, 32'h0, LX, SW, 32'hBEEF_AA44, 1'b0);

      // Error cases, each followed by a load proving memory is unchanged.
      applyStimulus(1'b1, 32'h04, 32'h5555_5555, LW, SW, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h06, 32'hDEAD_BEEF, LW, SW, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h04, 32'h0, LW, SW, 32'h5555_5555, 1'b0);
      applyStimulus(1'b0, 32'h05, 32'h0, LH, SW, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h400, 32'h0, LW, SW, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'hFFFF_FFFC, 32'h0, LW, SW, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h20, 32'h0000_0000, LW, SX, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h21, 32'h0000_0000, LW, SH, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h22, 32'h0, LX, SW, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h20, 32'h0, LW, SW, 32'hBEEF_AA44, 1'b0);

      // Last legal word.
      applyStimulus(1'b1, 32'h3FC, 32'hCAFE_F00D, LW, SW, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h3FC, 32'h0, LW, SW, 32'hCAFE_F00D, 1'b0);
      applyStimulus(1'b0, 32'h3FE, 32'h0, LHU, SW, 32'h0000_CAFE, 1'b0);
      idle(6);

      // Reset with two loads in flight: the latency-3 responses must vanish.
      applyStimulus(1'b0, 32'h10, 32'h0, LW, SW, 32'h8000_7F81, 1'b0);
      applyStimulus(1'b0, 32'h20, 32'h0, LW, SW, 32'hBEEF_AA44, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      keep = {};
      foreach (q1[i]) if (q1[i].exp_cyc <= cyc) keep.push_back(q1[i]);
      q1 = keep;
      keep = {};
      foreach (q3[i]) if (q3[i].exp_cyc <= cyc) keep.push_back(q3[i]);
      q3 = keep;
      repeat (2) @(negedge clk);
      checkResetState();
      releaseAndWaitInit(1'b0);

      applyStimulus(1'b0, 32'h10, 32'h0, LW, SW, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h20, 32'h0, LW, SW, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h3FC, 32'h0, LW, SW, 32'h0, 1'b0);
      idle(8);

      checks++;
      if (q1.size() != 0 || q3.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d/%0d outstanding, want 0/0", q1.size(), q3.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
